// File: rtl/tape_vga_renderer.sv
// tape_vga_renderer: 640x480 timing generator that fetches one tape byte per
// tile through the core's VGA read port and paints it as a coloured tile grid.
module tape_vga_renderer #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned TILE_SHIFT = 4,
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [13:0] vga_data_addr,
  input  logic [7:0]  vga_cell,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned CW      = HW - TILE_SHIFT;
  localparam int unsigned RW      = VW - TILE_SHIFT;
  localparam int unsigned AW      = 14;
  localparam int unsigned DW      = 8;
  localparam logic [AW-1:0] BASE  = AW'(BASE_ADDR);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          h_last, v_last;
  logic          active_c, in_grid_c, edge_c, hs_raw_c, vs_raw_c;
  logic [AW-1:0] row_base;

  logic [2:0]    grid_d, edge_d, hs_d, vs_d, vld_d;
  logic [1:0]    pe_d;
  logic [DW-1:0] cell_mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [DW-1:0] cell_c;
  logic [3:0]    red_c, green_c, blue_c;

  // Counter-stage decode: wrap points, visibility, sync windows, tile position
  always_comb begin
    h_last    = (hcount == HW'(H_TOTAL - 1));
    v_last    = (vcount == VW'(V_TOTAL - 1));
    col       = hcount[HW-1:TILE_SHIFT];
    row       = vcount[VW-1:TILE_SHIFT];
    active_c  = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE));
    in_grid_c = active_c && (col < CW'(COLS)) && (row < RW'(ROWS));
    edge_c    = (hcount[TILE_SHIFT-1:0] == '0) || (vcount[TILE_SHIFT-1:0] == '0);
    hs_raw_c  = !((hcount >= HW'(H_ACTIVE + H_FP)) &&
                  (hcount <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    vs_raw_c  = !((vcount >= VW'(V_ACTIVE + V_FP)) &&
                  (vcount <  VW'(V_ACTIVE + V_FP + V_SYNC)));
  end

  // Raster counters and the frame-wrap pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_last && v_last;
      if (pix_en) begin
        if (h_last) begin
          hcount <= '0;
          vcount <= v_last ? '0 : vcount + VW'(1);
        end else begin
          hcount <= hcount + HW'(1);
        end
      end
    end
  end

  // Tile-row base address, stepped by COLS at the end of each tile row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base <= BASE;
    end else if (pix_en && h_last) begin
      if (v_last)
        row_base <= BASE;
      else if (vcount[TILE_SHIFT-1:0] == '1)
        row_base <= row_base + AW'(COLS);
    end
  end

  // Read address for the current tile; held outside the grid
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      vga_data_addr <= BASE;
    else if (pix_en && in_grid_c)
      vga_data_addr <= row_base + AW'(col);
  end

  // Flag delay line keeping sync, grid and colour aligned over three ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid_d <= '0;
      edge_d <= '0;
      hs_d   <= '1;
      vs_d   <= '1;
      vld_d  <= '0;
    end else if (pix_en) begin
      grid_d <= {grid_d[1:0], in_grid_c};
      edge_d <= {edge_d[1:0], edge_c};
      hs_d   <= {hs_d[1:0], hs_raw_c};
      vs_d   <= {vs_d[1:0], vs_raw_c};
      vld_d  <= {vld_d[1:0], 1'b1};
    end
  end

  // Cell capture two clks after each tick, queued so any pix_en spacing lines up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_d   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      pe_d <= {pe_d[0], pix_en};
      if (pe_d[1])
        wr_ptr <= wr_ptr + 2'd1;
      if (pix_en && vld_d[2])
        rd_ptr <= rd_ptr + 2'd1;
    end
  end

  // Cell queue storage
  always_ff @(posedge clk) begin
    if (pe_d[1])
      cell_mem[wr_ptr] <= vga_cell;
  end

  // Tile colour from the queued cell, grey tile edges, black outside the grid
  always_comb begin
    red_c   = '0;
    green_c = '0;
    blue_c  = '0;
    cell_c  = cell_mem[rd_ptr];
    if (grid_d[2]) begin
      if (edge_d[2]) begin
        red_c   = 4'd2;
        green_c = 4'd2;
        blue_c  = 4'd2;
      end else begin
        red_c   = {cell_c[7:5], cell_c[7]};
        green_c = {cell_c[4:2], cell_c[4]};
        blue_c  = {cell_c[1:0], cell_c[1:0]};
      end
    end
  end

  // Registered pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_en) begin
      hsync <= hs_d[2];
      vsync <= vs_d[2];
      red   <= red_c;
      green <= green_c;
      blue  <= blue_c;
    end
  end

endmodule

// File: tb/tb_tape_vga_renderer.sv
// Bench for tape_vga_renderer: full-size instance plus a shrunken-timing
// instance (short frame, narrow grid, wrapping base address).
module tb_tape_vga_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b1;

  logic [13:0] vga_data_addr, s_addr;
  logic [7:0]  vga_cell, s_cell;
  logic        hsync, vsync, frame_start, s_hsync, s_vsync, s_fs;
  logic [3:0]  red, green, blue, s_red, s_green, s_blue;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tape_vga_renderer dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .vga_data_addr(vga_data_addr), .vga_cell(vga_cell),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  tape_vga_renderer #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .TILE_SHIFT(4), .COLS(1), .ROWS(2), .BASE_ADDR(16383)
  ) dut_s (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .vga_data_addr(s_addr), .vga_cell(s_cell),
    .hsync(s_hsync), .vsync(s_vsync), .red(s_red), .green(s_green), .blue(s_blue),
    .frame_start(s_fs)
  );

  // Tape contents seen by each instance
  function automatic logic [7:0] tape_cell(input bit s, input logic [13:0] a);
    if (s) return a[7:0] ^ 8'hA5;
    if (a == 14'd43) return 8'hFF;
    return a[7:0];
  endfunction

  // Synchronous-read tape: byte valid one clk after the address
  always @(posedge clk) begin
    vga_cell <= tape_cell(1'b0, vga_data_addr);
    s_cell   <= tape_cell(1'b1, s_addr);
  end

  // Expected {hsync, vsync, r, g, b} for raster position q (q<0: pipeline empty)
  function automatic logic [13:0] exp_out(input bit s, input int q);
    int ha, hf, hsy, ht, va, vf, vsy, vt, cols, rows, base, h, v, a;
    logic [7:0] c;
    logic [3:0] r, g, b;
    logic hs, vs;
    if (s) begin
      ha = 32; hf = 4; hsy = 8; ht = 48; va = 32; vf = 2; vsy = 2; vt = 40;
      cols = 1; rows = 2; base = 16383;
    end else begin
      ha = 640; hf = 16; hsy = 96; ht = 800; va = 480; vf = 10; vsy = 2; vt = 525;
      cols = 40; rows = 30; base = 0;
    end
    if (q < 0) return 14'h3000;
    h = q % ht;
    v = (q / ht) % vt;
    hs = !(h >= ha + hf && h < ha + hf + hsy);
    vs = !(v >= va + vf && v < va + vf + vsy);
    r = 4'd0; g = 4'd0; b = 4'd0;
    if (h < ha && v < va && (h / 16) < cols && (v / 16) < rows) begin
      if (h % 16 == 0 || v % 16 == 0) begin
        r = 4'd2; g = 4'd2; b = 4'd2;
      end else begin
        a = (base + (v / 16) * cols + h / 16) % 16384;
        c = tape_cell(s, 14'(a));
        r = {c[7:5], c[7]};
        g = {c[4:2], c[4]};
        b = {c[1:0], c[1:0]};
      end
    end
    return {hs, vs, r, g, b};
  endfunction

  // Expected read address right after the tick for raster position p
  function automatic logic [13:0] exp_addr(input bit s, input int p);
    int ht, vt, cols, rows, base, h, v, cl, a;
    if (s) begin ht = 48; vt = 40; cols = 1; rows = 2; base = 16383; end
    else begin ht = 800; vt = 525; cols = 40; rows = 30; base = 0; end
    h = p % ht;
    v = (p / ht) % vt;
    if (v < rows * 16) begin
      cl = (h / 16 < cols) ? h / 16 : cols - 1;
      a = base + (v / 16) * cols + cl;
    end else begin
      a = base + rows * cols - 1;
    end
    return 14'(a % 16384);
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pix_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({hsync, vsync, red, green, blue, frame_start} !== 15'h6000) begin
        n_err++;
        $display("FAIL reset_pins clk=%0d got=%h exp=6000", i, {hsync, vsync, red, green, blue, frame_start});
      end
      n_vec++;
      if (vga_data_addr !== 14'd0 || s_addr !== 14'd16383) begin
        n_err++;
        $display("FAIL reset_addr clk=%0d got=%0d/%0d exp=0/16383", i, vga_data_addr, s_addr);
      end
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_free_run();
    logic [13:0] got;
    logic [13:0] e;
    apply_reset();
    for (int k = 0; k < 17600; k++) begin
      @(posedge clk); #1;
      got = {hsync, vsync, red, green, blue};
      e = exp_out(1'b0, k - 3);
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL free_run_pix k=%0d got=%h exp=%h", k, got, e);
      end
      n_vec++;
      if (vga_data_addr !== exp_addr(1'b0, k)) begin
        n_err++;
        $display("FAIL free_run_addr k=%0d got=%0d exp=%0d", k, vga_data_addr, exp_addr(1'b0, k));
      end
      n_vec++;
      if (frame_start !== 1'b0) begin
        n_err++;
        $display("FAIL free_run_fs k=%0d got=%b exp=0", k, frame_start);
      end
      // Hand-computed checkpoints
      if (k == 658 || k == 755) begin
        n_vec++;
        if (hsync !== 1'b1) begin n_err++; $display("FAIL hsync_edge k=%0d got=%b exp=1", k, hsync); end
      end
      if (k == 659 || k == 754) begin
        n_vec++;
        if (hsync !== 1'b0) begin n_err++; $display("FAIL hsync_edge k=%0d got=%b exp=0", k, hsync); end
      end
      if (k == 15 || k == 624 || k == 700) begin
        n_vec++;
        if (vga_data_addr !== ((k == 15) ? 14'd0 : 14'd39)) begin
          n_err++; $display("FAIL line0_addr k=%0d got=%0d", k, vga_data_addr);
        end
      end
      if (k == 12800) begin
        n_vec++;
        if (vga_data_addr !== 14'd40) begin n_err++; $display("FAIL line16_addr got=%0d exp=40", vga_data_addr); end
      end
      if (k == 820) begin
        n_vec++;
        if ({red, green, blue} !== 12'h005) begin n_err++; $display("FAIL pix_17_1 got=%h exp=005", {red, green, blue}); end
      end
      if (k == 13620) begin
        n_vec++;
        if ({red, green, blue} !== 12'h245) begin n_err++; $display("FAIL pix_17_17 got=%h exp=245", {red, green, blue}); end
      end
      if (k == 4019) begin
        n_vec++;
        if ({red, green, blue} !== 12'h222) begin n_err++; $display("FAIL pix_16_5_edge got=%h exp=222", {red, green, blue}); end
      end
      if (k == 16856) begin
        n_vec++;
        if ({red, green, blue} !== 12'hFFF) begin n_err++; $display("FAIL pix_cell_ff got=%h exp=fff", {red, green, blue}); end
      end
    end
  endtask

  task automatic test_small_frame();
    logic [13:0] got;
    logic [13:0] e;
    apply_reset();
    for (int k = 0; k < 3850; k++) begin
      @(posedge clk); #1;
      got = {s_hsync, s_vsync, s_red, s_green, s_blue};
      e = exp_out(1'b1, k - 3);
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL small_pix k=%0d got=%h exp=%h", k, got, e);
      end
      n_vec++;
      if (s_addr !== exp_addr(1'b1, k)) begin
        n_err++;
        $display("FAIL small_addr k=%0d got=%0d exp=%0d", k, s_addr, exp_addr(1'b1, k));
      end
      n_vec++;
      if (s_fs !== ((k % 1920) == 1919)) begin
        n_err++;
        $display("FAIL small_frame_start k=%0d got=%b", k, s_fs);
      end
      if (k == 1919 || k == 3839) begin
        n_vec++;
        if (s_fs !== 1'b1) begin n_err++; $display("FAIL frame_start_pulse k=%0d got=%b exp=1", k, s_fs); end
      end
      if (k == 1634 || k == 1635 || k == 1731) begin
        n_vec++;
        if (s_vsync !== (k != 1635)) begin n_err++; $display("FAIL vsync_edge k=%0d got=%b", k, s_vsync); end
      end
      if (k == 0 || k == 769) begin
        n_vec++;
        if (s_addr !== ((k == 0) ? 14'd16383 : 14'd0)) begin
          n_err++; $display("FAIL addr_wrap k=%0d got=%0d", k, s_addr);
        end
      end
      if (k == 52 || k == 68) begin
        n_vec++;
        if ({s_red, s_green, s_blue} !== ((k == 52) ? 12'h4DA : 12'h000)) begin
          n_err++; $display("FAIL small_grid_edge k=%0d got=%h", k, {s_red, s_green, s_blue});
        end
      end
    end
  endtask

  task automatic test_sparse_pix_en();
    logic [57:0] got;
    logic [57:0] e;
    apply_reset();
    for (int k = 0; k < 1930; k++) begin
      pix_en = 1'b1;
      @(posedge clk); #1;
      pix_en = 1'b0;
      e = {exp_out(1'b0, k - 3), exp_addr(1'b0, k), exp_out(1'b1, k - 3), exp_addr(1'b1, k),
           1'b0, ((k % 1920) == 1919)};
      got = {hsync, vsync, red, green, blue, vga_data_addr,
             s_hsync, s_vsync, s_red, s_green, s_blue, s_addr, frame_start, s_fs};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL sparse_tick k=%0d got=%h exp=%h", k, got, e);
      end
      e[0] = 1'b0;
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        got = {hsync, vsync, red, green, blue, vga_data_addr,
               s_hsync, s_vsync, s_red, s_green, s_blue, s_addr, frame_start, s_fs};
        n_vec++;
        if (got !== e) begin
          n_err++;
          $display("FAIL sparse_hold k=%0d idle=%0d got=%h exp=%h", k, j, got, e);
        end
      end
    end
    pix_en = 1'b1;
  endtask

  task automatic test_midframe_reset();
    logic [13:0] got;
    logic [13:0] e;
    apply_reset();
    repeat (8300) @(posedge clk);
    #1;
    n_vec++;
    if ({red, green, blue} !== 12'h09A || vga_data_addr !== 14'd18) begin
      n_err++;
      $display("FAIL pre_reset got=%h/%0d exp=09a/18", {red, green, blue}, vga_data_addr);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({hsync, vsync, red, green, blue, frame_start} !== 15'h6000 || vga_data_addr !== 14'd0) begin
      n_err++;
      $display("FAIL async_reset got=%h/%0d exp=6000/0", {hsync, vsync, red, green, blue, frame_start}, vga_data_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 900; k++) begin
      @(posedge clk); #1;
      got = {hsync, vsync, red, green, blue};
      e = exp_out(1'b0, k - 3);
      n_vec++;
      if (got !== e || vga_data_addr !== exp_addr(1'b0, k)) begin
        n_err++;
        $display("FAIL restart k=%0d got=%h/%0d exp=%h/%0d", k, got, vga_data_addr, e, exp_addr(1'b0, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_small_frame();
    test_sparse_pix_en();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
